// File: rtl/pe_bf_pipe.sv
// Pipelined modular butterfly for NTT/INTT coefficient processing.
// Operands pass through PRE_DEPTH input registers, the add/sub/halve
// arithmetic sits between the last input register and the first output
// register, and POST_DEPTH output registers follow. Mode travels with
// its sample so mixed-mode streams compute correctly.
module pe_bf_pipe #(
    parameter int DATA_WIDTH = 14,
    parameter int Q          = 12289,
    parameter int PRE_DEPTH  = 3,
    parameter int POST_DEPTH = 3
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          ce,
    input  logic                                          valid_in,
    input  logic [1:0]                                    mode,
    input  logic [DATA_WIDTH-1:0]                         u,
    input  logic [DATA_WIDTH-1:0]                         v,
    output logic                                          valid_out,
    output logic [DATA_WIDTH-1:0]                         bf_upper,
    output logic [DATA_WIDTH-1:0]                         bf_lower,
    output logic [$clog2(PRE_DEPTH+POST_DEPTH+1)-1:0]     inflight,
    output logic                                          idle,
    output logic                                          range_err
);

    localparam int CNT_W = $clog2(PRE_DEPTH + POST_DEPTH + 1);
    localparam logic [DATA_WIDTH:0] Q_EXT = (DATA_WIDTH + 1)'(Q);

    typedef enum logic [1:0] {
        MODE_NTT    = 2'b00,
        MODE_INTT   = 2'b01,
        MODE_BYPASS = 2'b10,
        MODE_SWAP   = 2'b11
    } bf_mode_t;

    // Input-side pipeline registers
    logic [DATA_WIDTH-1:0] pre_u     [PRE_DEPTH];
    logic [DATA_WIDTH-1:0] pre_v     [PRE_DEPTH];
    bf_mode_t              pre_mode  [PRE_DEPTH];
    logic                  pre_valid [PRE_DEPTH];

    // Output-side pipeline registers
    logic [DATA_WIDTH-1:0] post_upper [POST_DEPTH];
    logic [DATA_WIDTH-1:0] post_lower [POST_DEPTH];
    logic                  post_valid [POST_DEPTH];

    logic [DATA_WIDTH-1:0] calc_upper;
    logic [DATA_WIDTH-1:0] calc_lower;

    logic accept;
    logic leave;
    logic out_of_range;

    // Modular add: one conditional subtraction of Q at DATA_WIDTH+1 bits.
    function automatic logic [DATA_WIDTH-1:0] mod_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q_EXT) begin
            s = s - Q_EXT;
        end
        return s[DATA_WIDTH-1:0];
    endfunction

    // Modular sub: adding Q before subtracting keeps the intermediate non-negative.
    function automatic logic [DATA_WIDTH-1:0] mod_sub(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] d;
        if (a < b) begin
            d = {1'b0, a} + Q_EXT - {1'b0, b};
        end else begin
            d = {1'b0, a} - {1'b0, b};
        end
        return d[DATA_WIDTH-1:0];
    endfunction

    // Division by two mod Q: odd values get Q added first (Q is odd, so the sum is even).
    function automatic logic [DATA_WIDTH-1:0] mod_half(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH:0] h;
        if (x[0]) begin
            h = {1'b0, x} + Q_EXT;
        end else begin
            h = {1'b0, x};
        end
        return h[DATA_WIDTH:1];
    endfunction

    assign accept       = ce && valid_in;
    assign leave        = post_valid[POST_DEPTH-1];
    assign out_of_range = ({1'b0, u} >= Q_EXT) || ({1'b0, v} >= Q_EXT);

    // Butterfly arithmetic on the sample sitting in the last input register.
    always_comb begin
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        a          = pre_u[PRE_DEPTH-1];
        b          = pre_v[PRE_DEPTH-1];
        calc_upper = '0;
        calc_lower = '0;
        case (pre_mode[PRE_DEPTH-1])
            MODE_NTT: begin
                calc_lower = mod_add(a, b);
                calc_upper = mod_sub(a, b);
            end
            MODE_INTT: begin
                calc_lower = mod_half(mod_add(a, b));
                calc_upper = mod_half(mod_sub(b, a));
            end
            MODE_BYPASS: begin
                calc_lower = a;
                calc_upper = b;
            end
            MODE_SWAP: begin
                calc_lower = b;
                calc_upper = a;
            end
            default: begin
                calc_lower = '0;
                calc_upper = '0;
            end
        endcase
    end

    // Input-side shift register; frozen whenever ce is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < PRE_DEPTH; i++) begin
                pre_u[i]     <= '0;
                pre_v[i]     <= '0;
                pre_mode[i]  <= MODE_NTT;
                pre_valid[i] <= 1'b0;
            end
        end else if (ce) begin
            pre_u[0]     <= u;
            pre_v[0]     <= v;
            pre_mode[0]  <= bf_mode_t'(mode);
            pre_valid[0] <= valid_in;
            for (int i = 1; i < PRE_DEPTH; i++) begin
                pre_u[i]     <= pre_u[i-1];
                pre_v[i]     <= pre_v[i-1];
                pre_mode[i]  <= pre_mode[i-1];
                pre_valid[i] <= pre_valid[i-1];
            end
        end
    end

    // Output-side shift register capturing the butterfly results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < POST_DEPTH; i++) begin
                post_upper[i] <= '0;
                post_lower[i] <= '0;
                post_valid[i] <= 1'b0;
            end
        end else if (ce) begin
            post_upper[0] <= calc_upper;
            post_lower[0] <= calc_lower;
            post_valid[0] <= pre_valid[PRE_DEPTH-1];
            for (int i = 1; i < POST_DEPTH; i++) begin
                post_upper[i] <= post_upper[i-1];
                post_lower[i] <= post_lower[i-1];
                post_valid[i] <= post_valid[i-1];
            end
        end
    end

    // Occupancy counter: +1 on accept, -1 when the output sample shifts out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight <= '0;
        end else if (ce) begin
            case ({accept, leave})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Sticky flag for any accepted operand outside [0, Q).
    always_ff @(posedge clk) begin
        if (!rst) begin
            range_err <= 1'b0;
        end else if (accept && out_of_range) begin
            range_err <= 1'b1;
        end
    end

    assign valid_out = post_valid[POST_DEPTH-1];
    assign bf_upper  = valid_out ? post_upper[POST_DEPTH-1] : '0;
    assign bf_lower  = valid_out ? post_lower[POST_DEPTH-1] : '0;
    assign idle      = (inflight == '0);

endmodule

// File: tb/tb_pe_bf_pipe.sv
// Directed bench for pe_bf_pipe with hand-computed butterfly results.
module tb_pe_bf_pipe;

    localparam int DW   = 14;
    localparam int QM   = 12289;
    localparam int PRE  = 3;
    localparam int POST = 3;
    localparam int L    = PRE + POST;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          valid_in;
    logic [1:0]    mode;
    logic [DW-1:0] u;
    logic [DW-1:0] v;
    logic          valid_out;
    logic [DW-1:0] bf_upper;
    logic [DW-1:0] bf_lower;
    logic [2:0]    inflight;
    logic          idle;
    logic          range_err;

    int errors = 0;
    int checks = 0;
    int seen   = 0;

    pe_bf_pipe #(
        .DATA_WIDTH (DW),
        .Q          (QM),
        .PRE_DEPTH  (PRE),
        .POST_DEPTH (POST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .valid_in  (valid_in),
        .mode      (mode),
        .u         (u),
        .v         (v),
        .valid_out (valid_out),
        .bf_upper  (bf_upper),
        .bf_lower  (bf_lower),
        .inflight  (inflight),
        .idle      (idle),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive all inputs at once; no clock edge is consumed here.
    task automatic applyStimulus(input logic c, input logic vi, input logic [1:0] m,
                                 input int a, input int b);
        ce       = c;
        valid_in = vi;
        mode     = m;
        u        = DW'(a);
        v        = DW'(b);
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let the pipeline empty out between tests.
    task automatic drain();
        applyStimulus(1'b1, 1'b0, 2'b00, 0, 0);
        repeat (L + 1) tick();
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0);
        tick();
        checkOutput("rst_valid_out", valid_out, 0);
        checkOutput("rst_idle", idle, 1);
        tick();
        checkOutput("rst_upper", bf_upper, 0);
        checkOutput("rst_lower", bf_lower, 0);
        checkOutput("rst_inflight", inflight, 0);
        checkOutput("rst_range_err", range_err, 0);

        // NTT(5,3) accepted on the first edge after reset release
        $display("[TB] NTT single sample");
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 2'b00, 5, 3);
        tick();
        applyStimulus(1'b1, 1'b0, 2'b00, 0, 0);
        checkOutput("ntt_inflight_e1", inflight, 1);
        checkOutput("ntt_novalid_e1", valid_out, 0);
        for (int e = 2; e <= 5; e++) begin
            tick();
            checkOutput($sformatf("ntt_inflight_e%0d", e), inflight, 1);
            checkOutput($sformatf("ntt_novalid_e%0d", e), valid_out, 0);
        end
        tick();
        checkOutput("ntt_valid_e6", valid_out, 1);
        checkOutput("ntt_upper", bf_upper, 2);
        checkOutput("ntt_lower", bf_lower, 8);
        tick();
        checkOutput("ntt_valid_e7", valid_out, 0);
        checkOutput("ntt_upper_zero", bf_upper, 0);
        checkOutput("ntt_idle_e7", idle, 1);
        drain();

        // NTT wrap-around in both directions, back to back
        $display("[TB] NTT wrap");
        applyStimulus(1'b1, 1'b1, 2'b00, 3, 5);
        tick();
        applyStimulus(1'b1, 1'b1, 2'b00, 12288, 1);
        tick();
        applyStimulus(1'b1, 1'b0, 2'b00, 0, 0);
        repeat (3) tick();
        tick();
        checkOutput("wrap1_valid", valid_out, 1);
        checkOutput("wrap1_upper", bf_upper, 12287);
        checkOutput("wrap1_lower", bf_lower, 8);
        tick();
        checkOutput("wrap2_valid", valid_out, 1);
        checkOutput("wrap2_lower", bf_lower, 0);
        checkOutput("wrap2_upper", bf_upper, 12287);
        drain();

        // INTT with even and odd halving
        $display("[TB] INTT");
        applyStimulus(1'b1, 1'b1, 2'b01, 3, 5);
        tick();
        applyStimulus(1'b1, 1'b1, 2'b01, 0, 1);
        tick();
        applyStimulus(1'b1, 1'b0, 2'b00, 0, 0);
        repeat (4) tick();
        checkOutput("intt1_valid", valid_out, 1);
        checkOutput("intt1_lower", bf_lower, 4);
        checkOutput("intt1_upper", bf_upper, 1);
        tick();
        checkOutput("intt2_valid", valid_out, 1);
        checkOutput("intt2_lower", bf_lower, 6145);
        checkOutput("intt2_upper", bf_upper, 6145);
        drain();

        // Mixed modes with a two-cycle stall; valid_in during the stall is ignored
        $display("[TB] mixed stream with stall");
        applyStimulus(1'b1, 1'b1, 2'b00, 5, 3);
        tick();
        applyStimulus(1'b1, 1'b1, 2'b01, 3, 5);
        tick();
        applyStimulus(1'b1, 1'b1, 2'b11, 7, 9);
        tick();
        applyStimulus(1'b0, 1'b1, 2'b10, 100, 200);
        for (int e = 4; e <= 5; e++) begin
            tick();
            checkOutput($sformatf("stall_novalid_e%0d", e), valid_out, 0);
            checkOutput($sformatf("stall_inflight_e%0d", e), inflight, 3);
        end
        applyStimulus(1'b1, 1'b0, 2'b00, 0, 0);
        for (int e = 6; e <= 7; e++) begin
            tick();
            checkOutput($sformatf("mix_novalid_e%0d", e), valid_out, 0);
        end
        tick();
        checkOutput("mix_ntt_valid", valid_out, 1);
        checkOutput("mix_ntt_upper", bf_upper, 2);
        checkOutput("mix_ntt_lower", bf_lower, 8);
        tick();
        checkOutput("mix_intt_valid", valid_out, 1);
        checkOutput("mix_intt_upper", bf_upper, 1);
        checkOutput("mix_intt_lower", bf_lower, 4);
        tick();
        checkOutput("mix_swap_valid", valid_out, 1);
        checkOutput("mix_swap_upper", bf_upper, 7);
        checkOutput("mix_swap_lower", bf_lower, 9);
        seen = 0;
        repeat (L) begin
            tick();
            if (valid_out) seen++;
        end
        checkOutput("mix_no_extra_valid", seen, 0);
        checkOutput("mix_idle", idle, 1);
        drain();

        // Out-of-range operand, then reset with samples in flight
        $display("[TB] range error and mid-stream reset");
        applyStimulus(1'b1, 1'b1, 2'b00, 12289, 0);
        tick();
        checkOutput("err_set", range_err, 1);
        applyStimulus(1'b1, 1'b1, 2'b00, 1, 2);
        tick();
        applyStimulus(1'b1, 1'b1, 2'b01, 3, 4);
        tick();
        applyStimulus(1'b1, 1'b1, 2'b10, 5, 6);
        tick();
        checkOutput("err_inflight4", inflight, 4);
        checkOutput("err_sticky", range_err, 1);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'b00, 1, 1);
        tick();
        checkOutput("mreset_inflight", inflight, 0);
        checkOutput("mreset_range_err", range_err, 0);
        checkOutput("mreset_valid_out", valid_out, 0);
        checkOutput("mreset_idle", idle, 1);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'b00, 0, 0);
        seen = 0;
        repeat (L) begin
            tick();
            if (valid_out) seen++;
        end
        checkOutput("post_reset_no_valid", seen, 0);
        checkOutput("post_reset_idle", idle, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_bf_pipe.md
PE_BF_PIPE -- requirements
Module: pe_bf_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14, coefficient width in bits.
REQ-002 SHALL have parameter Q, default 12289, modulus; legal values are odd and satisfy 2 < Q < 2^DATA_WIDTH.
REQ-003 SHALL have parameter PRE_DEPTH, default 3, number of register stages before the add/sub stage; legal values are >= 1.
REQ-004 SHALL have parameter POST_DEPTH, default 3, number of register stages after the add/sub stage; legal values are >= 1.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; every register is clocked on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset, synchronous and active-low.
REQ-007 SHALL have port ce, input, 1 bit, pipeline advance enable.
REQ-008 SHALL have port valid_in, input, 1 bit, u/v/mode hold a sample.
REQ-009 SHALL have port mode, input, 2 bits: 00 NTT (CT), 01 INTT (GS with halving), 10 bypass, 11 swap.
REQ-010 SHALL have ports u and v, inputs, DATA_WIDTH bits each, operands.
REQ-011 SHALL have port valid_out, output, 1 bit, bf_upper/bf_lower hold a result.
REQ-012 SHALL have ports bf_upper and bf_lower, outputs, DATA_WIDTH bits each, results.
REQ-013 SHALL have port inflight, output, clog2(PRE_DEPTH+POST_DEPTH+1) bits, count of valid samples currently in the pipeline.
REQ-014 SHALL have port idle, output, 1 bit, high when inflight == 0.
REQ-015 SHALL have port range_err, output, 1 bit, sticky flag for an out-of-range operand.

Function
REQ-016 SHALL have a latency of L = PRE_DEPTH+POST_DEPTH advancing cycles; a sample accepted on the edge where ce=1 and valid_in=1 appears with valid_out=1 after exactly L edges with ce=1.
REQ-017 SHALL freeze every data, mode and valid register when ce=0, and SHALL accept no input on that edge.
REQ-018 SHALL carry mode through the pipeline alongside its sample, so back-to-back samples of different modes are each computed in their own mode.
REQ-019 SHALL compute, in NTT mode: bf_lower = (u+v) mod Q and bf_upper = (u-v) mod Q.
REQ-020 SHALL compute, in INTT mode: bf_lower = half((u+v) mod Q) and bf_upper = half((v-u) mod Q).
REQ-021 SHALL define half(x) as x/2 when x is even and (x+Q)/2 when x is odd; the intermediate x+Q SHALL be formed at DATA_WIDTH+1 bits with no overflow.
REQ-022 SHALL compute, in bypass mode: bf_lower = u and bf_upper = v; in swap mode: bf_lower = v and bf_upper = u.
REQ-023 SHALL form modular add as s = u+v at DATA_WIDTH+1 bits, then subtract Q once if s >= Q.
REQ-024 SHALL form modular sub as d = a-b, then add Q once if a < b.
REQ-025 SHALL fully reduce every result in [0, Q) whenever both operands are < Q.
REQ-026 SHALL drive bf_upper and bf_lower to 0 whenever valid_out=0.
REQ-027 SHALL set range_err to 1 on an accepted sample (ce=1, valid_in=1) with u >= Q or v >= Q, in any mode, and SHALL hold it at 1 until reset.
REQ-028 SHALL still process an out-of-range sample; its result values are unspecified.
REQ-029 SHALL update inflight on each ce=1 edge by +1 for an accepted sample and -1 for a sample leaving the pipeline; when both occur on one edge inflight SHALL be unchanged; inflight SHALL never exceed L.
REQ-030 SHALL ignore valid_in whenever ce=0.

Reset
REQ-031 SHALL, on an edge with rst=0, clear all valid bits, data registers, mode registers, inflight and range_err to 0, regardless of ce.
REQ-032 SHALL drive valid_out=0, bf_upper=0, bf_lower=0 and idle=1 from the first edge with rst=0.
REQ-033 SHALL discard samples in flight when reset is asserted mid-stream; none of them SHALL emerge after reset releases.
REQ-034 SHALL accept a sample on the first edge with rst=1.

Verification (DATA_WIDTH=14, Q=12289, PRE=POST=3, L=6)
REQ-035 NTT: u=5, v=3, ce=1 -> at edge 6, valid_out=1, bf_upper=2, bf_lower=8; inflight reads 1 between acceptance and that edge.
REQ-036 NTT wrap: u=3, v=5 gives bf_upper=12287; then u=12288, v=1 gives bf_lower=0; both results on consecutive cycles.
REQ-037 INTT: u=3, v=5 -> bf_lower=4, bf_upper=1; u=0, v=1 -> bf_lower=6145, bf_upper=6145.
REQ-038 Mixed stream: NTT(5,3), INTT(3,5), swap(7,9) on consecutive cycles, then ce=0 for 2 cycles mid-flight -> (2,8), (1,4), (upper 7, lower 9) emerge at edges 8, 9 and 10; the bench observes no valid_out during the stall.
REQ-039 Error and reset: u=12289 accepted -> range_err=1 and it stays 1; rst=0 for one cycle with 4 samples in flight -> inflight=0, range_err=0, and no valid_out for 6 cycles after release.
